// File: rtl/hex_entry_ctrl.sv
// Hex keypad entry controller.
// Synchronises the pushbuttons and debounces them, then turns each clean single-key
// press into one editing event on a bank of NDIGITS hex digits.
// MODE 0 overwrites the digit under a movable cursor; MODE 1 shifts new digits in at position 0.
module hex_entry_ctrl #(
  parameter int NDIGITS = 8,
  parameter int DEB     = 2,
  parameter int MODE    = 0,
  localparam int CW     = (NDIGITS > 1) ? $clog2(NDIGITS) : 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [15:0]              pb,
  input  logic                     cur_left,
  input  logic                     cur_right,
  input  logic                     bksp,
  input  logic                     clr,
  input  logic                     enter,
  output logic [NDIGITS-1:0][3:0]  digits,
  output logic [NDIGITS-1:0]       flt_pt,
  output logic [CW-1:0]            cursor,
  output logic [4*NDIGITS-1:0]     value,
  output logic                     value_valid
);

  typedef enum logic [1:0] {IDLE, CHECK, HELD, RELEASE} state_t;

  localparam logic [7:0]    DEB_CNT = 8'(DEB);
  localparam logic [CW-1:0] CUR_MAX = CW'(NDIGITS - 1);

  logic [20:0] sync1;
  logic [20:0] raw;
  state_t      state, state_nxt;
  logic [20:0] sample, sample_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic        fire;
  logic        one_hot;
  logic [3:0]  key_val;

  // Two-flop synchroniser on every button input.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1 <= '0;
      raw   <= '0;
    end else begin
      sync1 <= {enter, clr, bksp, cur_right, cur_left, pb};
      raw   <= sync1;
    end
  end

  // Debounce state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      sample <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      sample <= sample_nxt;
      cnt    <= cnt_nxt;
    end
  end

  // sample is never zero while in CHECK, so this zero test is also a one-hot test.
  assign one_hot = (sample & (sample - 21'd1)) == '0;

  // Debounce next state: a sample must stay stable for DEB checks to fire a single event.
  // It must then be released for DEB checks before the controller will accept another press.
  always_comb begin
    state_nxt  = state;
    sample_nxt = sample;
    cnt_nxt    = cnt;
    fire       = 1'b0;
    case (state)
      IDLE: begin
        if (raw != '0) begin
          sample_nxt = raw;
          cnt_nxt    = 8'd1;
          state_nxt  = CHECK;
        end
      end
      CHECK: begin
        if (raw == '0) begin
          state_nxt = IDLE;
        end else if (raw != sample) begin
          sample_nxt = raw;
          cnt_nxt    = 8'd1;
        end else if (cnt >= DEB_CNT) begin
          fire      = one_hot;
          state_nxt = HELD;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      HELD: begin
        if (raw == '0) begin
          cnt_nxt   = 8'd1;
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        if (raw != '0) begin
          state_nxt = HELD;
        end else if (cnt >= DEB_CNT) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Digit value of the accepted hex key.
  always_comb begin
    key_val = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (sample[i]) key_val = 4'(i);
    end
  end

  // Apply the single debounced event to the digits, cursor and committed value.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      digits      <= '0;
      cursor      <= '0;
      value       <= '0;
      value_valid <= 1'b0;
    end else begin
      value_valid <= 1'b0;
      if (fire) begin
        if (sample[15:0] != '0) begin
          if (MODE == 0) digits[cursor] <= key_val;
          else           digits <= {digits[NDIGITS-2:0], key_val};
        end
        if (sample[16] && MODE == 0) begin
          cursor <= (cursor == CUR_MAX) ? '0 : cursor + 1'b1;
        end
        if (sample[17] && MODE == 0) begin
          cursor <= (cursor == '0) ? CUR_MAX : cursor - 1'b1;
        end
        if (sample[18]) begin
          if (MODE == 0) digits[cursor] <= 4'h0;
          else           digits <= {4'h0, digits[NDIGITS-1:1]};
        end
        if (sample[19]) begin
          digits <= '0;
          cursor <= '0;
        end
        if (sample[20]) begin
          value       <= digits;
          value_valid <= 1'b1;
        end
      end
    end
  end

  // Decimal point marks the cursor in overwrite mode only.
  always_comb begin
    flt_pt = '0;
    if (MODE == 0) flt_pt[cursor] = 1'b1;
  end

endmodule

// File: tb/tb_hex_entry_ctrl.sv
// Bench for hex_entry_ctrl: three instances (8-digit overwrite, 8-digit shift-in,
// 6-digit overwrite) share one stimulus and are compared with an event-level model.
module tb_hex_entry_ctrl;

  localparam int DEB = 3;

  logic        CLK = 1'b0;
  logic        RST;
  logic [20:0] stim;

  logic [7:0][3:0] dig0, dig1;
  logic [5:0][3:0] dig2;
  logic [7:0]      fp0, fp1;
  logic [5:0]      fp2;
  logic [2:0]      cur0, cur1, cur2;
  logic [31:0]     val0, val1;
  logic [23:0]     val2;
  logic            vv0, vv1, vv2;

  int nvec = 0;
  int nfail = 0;

  always #5 CLK = ~CLK;

  hex_entry_ctrl #(.NDIGITS(8), .DEB(DEB), .MODE(0)) u0 (
    .CLK(CLK), .RST(RST), .pb(stim[15:0]), .cur_left(stim[16]), .cur_right(stim[17]),
    .bksp(stim[18]), .clr(stim[19]), .enter(stim[20]),
    .digits(dig0), .flt_pt(fp0), .cursor(cur0), .value(val0), .value_valid(vv0));

  hex_entry_ctrl #(.NDIGITS(8), .DEB(DEB), .MODE(1)) u1 (
    .CLK(CLK), .RST(RST), .pb(stim[15:0]), .cur_left(stim[16]), .cur_right(stim[17]),
    .bksp(stim[18]), .clr(stim[19]), .enter(stim[20]),
    .digits(dig1), .flt_pt(fp1), .cursor(cur1), .value(val1), .value_valid(vv1));

  hex_entry_ctrl #(.NDIGITS(6), .DEB(DEB), .MODE(0)) u2 (
    .CLK(CLK), .RST(RST), .pb(stim[15:0]), .cur_left(stim[16]), .cur_right(stim[17]),
    .bksp(stim[18]), .clr(stim[19]), .enter(stim[20]),
    .digits(dig2), .flt_pt(fp2), .cursor(cur2), .value(val2), .value_valid(vv2));

  // Reference model: raw input history, a press tracker and plain digit arrays.
  int         nd[3]   = '{8, 8, 6};
  int         mode[3] = '{0, 1, 0};
  logic [3:0] md[3][16];
  logic [3:0] mval[3][16];
  int         mc[3];
  bit         mvv[3];
  logic [20:0] d1, d2;
  bit         armed;
  int         run, zrun;
  logic [20:0] runv;

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 16; i++) begin md[d][i] = '0; mval[d][i] = '0; end
      mc[d] = 0; mvv[d] = 0;
    end
    d1 = '0; d2 = '0; armed = 1; run = 0; zrun = 0; runv = '0;
  endtask

  task automatic apply_event(input logic [20:0] r);
    for (int d = 0; d < 3; d++) begin
      mvv[d] = 0;
      if (r[15:0] != 0) begin
        int k = $clog2(r[15:0]);
        if (mode[d] == 0) md[d][mc[d]] = 4'(k);
        else begin
          for (int i = nd[d] - 1; i >= 1; i--) md[d][i] = md[d][i-1];
          md[d][0] = 4'(k);
        end
      end
      if (r[16] && mode[d] == 0) mc[d] = (mc[d] + 1) % nd[d];
      if (r[17] && mode[d] == 0) mc[d] = (mc[d] + nd[d] - 1) % nd[d];
      if (r[18]) begin
        if (mode[d] == 0) md[d][mc[d]] = 4'h0;
        else begin
          for (int i = 0; i < nd[d] - 1; i++) md[d][i] = md[d][i+1];
          md[d][nd[d]-1] = 4'h0;
        end
      end
      if (r[19]) begin
        for (int i = 0; i < 16; i++) md[d][i] = '0;
        mc[d] = 0;
      end
      if (r[20]) begin
        for (int i = 0; i < 16; i++) mval[d][i] = md[d][i];
        mvv[d] = 1;
      end
    end
  endtask

  // One clock edge of the model: a press fires after DEB+1 identical non-zero samples,
  // and a new press is accepted only after DEB+1 zero samples.
  task automatic model_step(input logic [20:0] in);
    logic [20:0] r;
    r = d2; d2 = d1; d1 = in;
    for (int d = 0; d < 3; d++) mvv[d] = 0;
    if (armed) begin
      if (r == 0) run = 0;
      else if (run > 0 && r == runv) run++;
      else begin runv = r; run = 1; end
      if (run == DEB + 1) begin
        armed = 0; zrun = 0;
        if ($countones(r) == 1) apply_event(r);
      end
    end else begin
      if (r == 0) begin
        zrun++;
        if (zrun == DEB + 1) begin armed = 1; run = 0; end
      end else zrun = 0;
    end
  endtask

  function automatic logic [63:0] mpack(input int d, input bit committed);
    logic [63:0] p = '0;
    for (int i = 0; i < nd[d]; i++) p[4*i +: 4] = committed ? mval[d][i] : md[d][i];
    return p;
  endfunction

  function automatic logic [7:0] mflt(input int d);
    logic [7:0] f = '0;
    if (mode[d] == 0) f[mc[d]] = 1'b1;
    return f;
  endfunction

  task automatic tick();
    @(posedge CLK);
    model_step(stim);
    @(negedge CLK);
  endtask

  task automatic press(input logic [20:0] v, input int hold, input int gap);
    stim = v;
    repeat (hold) tick();
    stim = '0;
    repeat (gap) tick();
  endtask

  task automatic test_reset();
    stim = 21'h20;
    repeat (4) tick();
    RST = 1'b1;
    model_reset();
    #1;
    nvec++; if (dig0 !== '0) begin nfail++; $display("FAIL rst_digits got %h want 0", dig0); end
    nvec++; if (cur0 !== 3'd0) begin nfail++; $display("FAIL rst_cursor got %0d want 0", cur0); end
    nvec++; if (fp0 !== 8'h01) begin nfail++; $display("FAIL rst_flt_pt0 got %h want 01", fp0); end
    nvec++; if (fp1 !== 8'h00) begin nfail++; $display("FAIL rst_flt_pt1 got %h want 00", fp1); end
    nvec++; if (vv0 !== 1'b0) begin nfail++; $display("FAIL rst_valid got %b want 0", vv0); end
    nvec++; if (val0 !== '0) begin nfail++; $display("FAIL rst_value got %h want 0", val0); end
    #1 RST = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      nvec++;
      if (dig0[0] !== ((e >= 3 + DEB) ? 4'h5 : 4'h0)) begin
        nfail++; $display("FAIL rst_relatch edge %0d got %h want %h", e, dig0[0], (e >= 3 + DEB) ? 4'h5 : 4'h0);
      end
    end
    stim = '0;
    repeat (8) tick();
  endtask

  task automatic test_entry();
    press(21'h80000, 6, 8);
    stim = 21'h00400;
    for (int e = 1; e <= 10; e++) begin
      tick();
      nvec++;
      if (dig0[0] !== ((e >= 6) ? 4'hA : 4'h0)) begin
        nfail++; $display("FAIL entry_latency edge %0d got %h want %h", e, dig0[0], (e >= 6) ? 4'hA : 4'h0);
      end
    end
    stim = '0;
    repeat (8) tick();
    press(21'h10000, 6, 8);
    press(21'h10000, 6, 8);
    press(21'h00008, 6, 8);
    nvec++; if (dig0 !== 32'h0000030A) begin nfail++; $display("FAIL entry_digits got %h want 0000030a", dig0); end
    nvec++; if (fp0 !== 8'h04) begin nfail++; $display("FAIL entry_flt_pt got %h want 04", fp0); end
    nvec++; if (dig2 !== 24'h00030A) begin nfail++; $display("FAIL entry_digits6 got %h want 00030a", dig2); end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 8; i++) begin
      stim = (i % 2 == 0) ? 21'h00080 : 21'h0;
      tick();
    end
    stim = 21'h00080;
    repeat (2) tick();
    stim = '0;
    repeat (8) tick();
    nvec++; if (dig0 !== 32'h0000030A) begin nfail++; $display("FAIL bounce got %h want 0000030a", dig0); end
    press(21'h00006, 10, 8);
    nvec++; if (dig0 !== 32'h0000030A) begin nfail++; $display("FAIL multikey got %h want 0000030a", dig0); end
    press(21'h80000, 6, 8);
    press(21'h20000, 6, 8);
    nvec++; if (cur0 !== 3'd7) begin nfail++; $display("FAIL right_wrap got %0d want 7", cur0); end
    nvec++; if (fp0 !== 8'h80) begin nfail++; $display("FAIL right_wrap_flt got %h want 80", fp0); end
    nvec++; if (cur2 !== 3'd5) begin nfail++; $display("FAIL right_wrap6 got %0d want 5", cur2); end
    nvec++; if (cur1 !== 3'd0) begin nfail++; $display("FAIL shift_cursor got %0d want 0", cur1); end
  endtask

  task automatic test_shift();
    press(21'h80000, 6, 8);
    for (int k = 1; k <= 4; k++) press(21'(1 << k), 6, 8);
    nvec++; if (dig1 !== 32'h00001234) begin nfail++; $display("FAIL shift_in got %h want 00001234", dig1); end
    press(21'h40000, 6, 8);
    nvec++; if (dig1 !== 32'h00000123) begin nfail++; $display("FAIL shift_bksp got %h want 00000123", dig1); end
    for (int k = 5; k <= 13; k++) press(21'(1 << k), 6, 8);
    nvec++; if (dig1 !== 32'h6789ABCD) begin nfail++; $display("FAIL shift_overflow got %h want 6789abcd", dig1); end
  endtask

  task automatic test_commit();
    int pulses = 0;
    press(21'h80000, 6, 8);
    for (int k = 1; k <= 4; k++) press(21'(1 << k), 6, 8);
    stim = 21'h100000;
    for (int c = 0; c < 58; c++) begin
      if (c == 50) stim = '0;
      tick();
      if (vv1 === 1'b1) pulses++;
    end
    nvec++; if (pulses != 1) begin nfail++; $display("FAIL commit_pulses got %0d want 1", pulses); end
    nvec++; if (val1 !== 32'h00001234) begin nfail++; $display("FAIL commit_value got %h want 00001234", val1); end
    nvec++; if (val0 !== 32'h00000004) begin nfail++; $display("FAIL commit_value0 got %h want 00000004", val0); end
    press(21'h80000, 6, 8);
    nvec++; if (dig1 !== '0) begin nfail++; $display("FAIL clr_digits got %h want 0", dig1); end
    nvec++; if (val1 !== 32'h00001234) begin nfail++; $display("FAIL clr_keeps_value got %h want 00001234", val1); end
  endtask

  task automatic test_wrap6();
    int seq[6] = '{1, 2, 3, 4, 5, 0};
    press(21'h80000, 6, 8);
    for (int i = 0; i < 6; i++) begin
      press(21'h10000, 6, 8);
      nvec++;
      if (cur2 !== 3'(seq[i])) begin nfail++; $display("FAIL wrap6 step %0d got %0d want %0d", i, cur2, seq[i]); end
    end
  endtask

  task automatic test_random();
    logic [63:0] e0, e1, e2;
    logic [7:0]  f0, f1, f2;
    for (int n = 0; n < 80; n++) begin
      int sel, hold, gap;
      logic [20:0] v;
      sel = $urandom_range(0, 26);
      if (sel < 16) v = 21'(1 << sel);
      else if (sel < 21) v = 21'(1 << sel);
      else v = 21'(1 << $urandom_range(0, 20)) | 21'(1 << $urandom_range(0, 20));
      hold = $urandom_range(1, 8);
      gap = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(5, 9);
      for (int c = 0; c < hold + gap; c++) begin
        stim = (c < hold) ? v : '0;
        tick();
        e0 = mpack(0, 0); e1 = mpack(1, 0); e2 = mpack(2, 0);
        f0 = mflt(0); f1 = mflt(1); f2 = mflt(2);
        nvec++; if (dig0 !== e0[31:0]) begin nfail++; $display("FAIL rnd_digits0 got %h want %h", dig0, e0[31:0]); end
        nvec++; if (dig1 !== e1[31:0]) begin nfail++; $display("FAIL rnd_digits1 got %h want %h", dig1, e1[31:0]); end
        nvec++; if (dig2 !== e2[23:0]) begin nfail++; $display("FAIL rnd_digits2 got %h want %h", dig2, e2[23:0]); end
        nvec++; if (cur0 !== 3'(mc[0]) || cur2 !== 3'(mc[2]) || cur1 !== 3'd0) begin
          nfail++; $display("FAIL rnd_cursor got %0d/%0d/%0d want %0d/0/%0d", cur0, cur1, cur2, mc[0], mc[2]);
        end
        nvec++; if (fp0 !== f0 || fp1 !== f1 || fp2 !== f2[5:0]) begin
          nfail++; $display("FAIL rnd_flt_pt got %h/%h/%h want %h/%h/%h", fp0, fp1, fp2, f0, f1, f2[5:0]);
        end
        e0 = mpack(0, 1); e1 = mpack(1, 1); e2 = mpack(2, 1);
        nvec++; if (val0 !== e0[31:0] || val1 !== e1[31:0] || val2 !== e2[23:0]) begin
          nfail++; $display("FAIL rnd_value got %h/%h/%h want %h/%h/%h", val0, val1, val2, e0[31:0], e1[31:0], e2[23:0]);
        end
        nvec++; if (vv0 !== mvv[0] || vv1 !== mvv[1] || vv2 !== mvv[2]) begin
          nfail++; $display("FAIL rnd_valid got %b%b%b want %b%b%b", vv0, vv1, vv2, mvv[0], mvv[1], mvv[2]);
        end
      end
    end
  endtask

  initial begin
    RST = 1'b1;
    stim = '0;
    model_reset();
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    test_reset();
    test_entry();
    test_bounce();
    test_shift();
    test_commit();
    test_wrap6();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/hex_entry_ctrl.md
Name: hex_entry_ctrl

Overview:
- Parametrised hex keypad entry controller: next generation of the board's single-digit type-in logic.
- Adds input synchronisation, debounce and one-event-per-press handling, plus cursor left/right with wrap, backspace, clear and enter/commit.
- Adds an optional calculator-style shift-in mode.
- Sits between the pushbutton inputs and the seven-segment decoder. Its digits/flt_pt outputs feed the decoder directly, and its committed value feeds downstream logic.

Parameters:
- NDIGITS, 8, number of 4-bit digits held and displayed (legal 2..16).
- DEB, 2, consecutive stable synchronised samples required to accept a press or a release (legal 1..255).
- MODE, 0, 0 = cursor-overwrite entry, 1 = shift-in entry (new digit enters at position 0).

Ports:
- CLK  in  1  system clock (hz100 on the board).
- RST  in  1  asynchronous, active-high reset.
- pb  in  16  hex keys; bit k enters digit value k.
- cur_left  in  1  move cursor toward MSD.
- cur_right  in  1  move cursor toward LSD.
- bksp  in  1  backspace.
- clr  in  1  clear all digits.
- enter  in  1  commit displayed digits.
- digits  out  NDIGITS x 4  working digits; index 0 is the rightmost digit.
- flt_pt  out  NDIGITS  decimal-point cursor marker.
- cursor  out  max(1,$clog2(NDIGITS))  current cursor index.
- value  out  4*NDIGITS  last committed digits, packed with digit i at bits [4i+3:4i].
- value_valid  out  1  one-cycle pulse when value updates.

Behaviour:
- Interface: one clock CLK. Reset RST is asynchronous and active-high.
- Reset (async, on RST high): all synchroniser flops, digits, cursor, value, value_valid, debounce state and counter go to 0. flt_pt follows cursor combinationally, so it is 1 in MODE 0 and 0 in MODE 1. RST mid-press drops the press; after RST falls, a still-held key must go through the full debounce before it is accepted.
- Synchroniser: all 21 inputs pass through 2 flops. raw = {enter, clr, bksp, cur_right, cur_left, pb}.
- Debounce FSM, states IDLE, CHECK, HELD, RELEASE:
  - IDLE: when raw != 0, latch sample = raw, cnt = 1, go to CHECK.
  - CHECK:
    - raw == 0: go to IDLE.
    - raw != sample: sample = raw, cnt = 1.
    - otherwise cnt++.
    - When cnt reaches DEB with raw == sample: if sample is one-hot, fire exactly one event that cycle; in all cases go to HELD. A multi-key sample is ignored.
    - DEB == 1: fire on the cycle after entering CHECK if raw is unchanged.
  - HELD: stay while raw != 0, with no repeat events. When raw == 0: cnt = 1, go to RELEASE.
  - RELEASE:
    - raw != 0: go back to HELD.
    - Each cycle with raw == 0: cnt++. When cnt reaches DEB, go to IDLE.
- Latency: a key held clean from the first CLK edge that samples it high updates digits on edge 3+DEB (2 sync edges, 1 IDLE->CHECK edge, DEB-1 count edges, 1 event edge).
- Events apply on the event edge:
  - hex k, MODE 0: digits[cursor] = k. Cursor does not move.
  - hex k, MODE 1: digits[i] = digits[i-1] for i >= 1, then digits[0] = k. digits[NDIGITS-1] is discarded.
  - cur_left: cursor = (cursor == NDIGITS-1) ? 0 : cursor+1. Ignored in MODE 1.
  - cur_right: cursor = (cursor == 0) ? NDIGITS-1 : cursor-1. Ignored in MODE 1.
  - bksp, MODE 0: digits[cursor] = 0.
  - bksp, MODE 1: digits[i] = digits[i+1], then digits[NDIGITS-1] = 0.
  - clr: all digits 0 and cursor 0. value is not affected.
  - enter: value <= digits packed, value_valid = 1 for exactly that one following cycle. value holds until the next enter or RST.
- Cursor stays in range 0..NDIGITS-1 for non-power-of-2 NDIGITS. In MODE 1, cursor is held at 0.
- flt_pt: MODE 0 = one-hot(cursor). MODE 1 = all zeros.
- Only one event can fire per cycle, because a one-hot sample is required, so simultaneous commands cannot conflict.

Test Plan:
- RST pulse mid-CHECK with pb[5] held (NDIGITS=8, DEB=3, MODE 0) -> digits=0, cursor=0, flt_pt=8'h01, value_valid=0. After RST falls, the digit is written only after a full 3+DEB edges.
- MODE 0: press pb[10] for 10 cycles -> digits[0]=4'hA written exactly once, at edge 6. Then cur_left x2 and pb[3] -> digits = 0x00000 3 0 A (digits[2]=3), flt_pt=8'h04.
- Bounce: pb[7] toggling every cycle for 8 cycles, then held 2 cycles (DEB=3) -> no event. Two keys pb[1]|pb[2] held 10 cycles -> no change. cur_right at cursor 0 -> cursor 7, flt_pt=8'h80.
- MODE 1: enter 1,2,3,4 in sequence -> digits read 0x00001234. bksp -> 0x00000123. 9 further key presses overflow the oldest digit out of position 7.
- enter after 0x1234 -> value=32'h00001234 with a one-cycle value_valid pulse. clr -> digits 0, value still 32'h00001234. Holding enter 50 cycles -> exactly one pulse.
- NDIGITS=6, MODE 0: cur_left x6 -> cursor sequence 1,2,3,4,5,0.
